regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the single-issue/single-commit architectural register file. Holds committed register values plus a per-register rename tag: the wrapped ROB position of the youngest in-flight writer, 0 meaning no pending writer.
- Serves NUM_READ combinational read ports to decode, one issue-rename port, and NUM_COMMIT in-order commit ports from the ROB.
- Adds same-cycle multi-commit ordering, commit-while-flush value retention and an optional busy bitmap.

Parameters:
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W; register 0 hardwired to zero.
- DATA_W, 32, register value width.
- TAG_W, 5, ROB wrapped-position width; tag value 0 is reserved for "no pending writer".
- NUM_READ, 2, number of decode read ports (1..4).
- NUM_COMMIT, 2, number of commit ports (1..2). Port k+1 is younger than port k.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes all state updates except clr
- clr  in  1  flush (mispredict): clears all tags
- iss_en  in  1  issue rename valid
- iss_rd  in  ADDR_W  destination register
- iss_tag  in  TAG_W  ROB position allocated to the issuing instruction
- cm_en  in  NUM_COMMIT  per-port commit valid
- cm_rd  in  NUM_COMMIT*ADDR_W  per-port destination, flattened, port 0 in LSBs
- cm_tag  in  NUM_COMMIT*TAG_W  per-port ROB position
- cm_val  in  NUM_COMMIT*DATA_W  per-port result value
- rd_addr  in  NUM_READ*ADDR_W  read addresses, flattened
- rd_val  out  NUM_READ*DATA_W  read values, combinational
- rd_tag  out  NUM_READ*TAG_W  read tags, combinational; 0 means rd_val is final
- busy_vec  out  NUM_REGS  bit r set when tag[r]!=0 (see Optional Feature)

Behaviour:
- Storage: val[NUM_REGS], tag[NUM_REGS].
- rst asserted (async): all val and tag become 0 immediately. Outputs follow combinationally: rd_val=0, rd_tag=0, busy_vec=0.
- A commit port k is effective when cm_en[k] && cm_rd[k]!=0. It matches when, in addition, tag[cm_rd[k]]==cm_tag[k] (pre-update state).
- Read path (combinational, per port p):
  - Default: rd_val=val[rd_addr], rd_tag=tag[rd_addr].
  - Bypass: if some matching effective commit port targets rd_addr, rd_val is that port's cm_val and rd_tag=0. The highest-numbered (youngest) such port wins.
  - Reads never see the same-cycle issue rename. Decode resolves self-dependency itself.
  - rd_addr=0 always returns val 0, tag 0.
- Sequential update on posedge clk, rst deasserted, in priority order:
  - clr=1, regardless of rdy: every tag becomes 0. iss_en is ignored. If rdy=1, effective commits still write val (no tag check). The youngest port wins on equal rd.
  - rdy=0 and clr=0: no state change.
  - Otherwise, commits:
    - Each effective port writes val[cm_rd]. On equal rd across ports, the youngest port's value is stored.
    - A matching port clears tag[cm_rd] to 0. Match is evaluated against the pre-cycle tag, so at most one port can match per register.
  - Otherwise, issue: if iss_en && iss_rd!=0, tag[iss_rd] <= iss_tag. This overrides any same-cycle commit clear of the same register.
- val[0] and tag[0] are never written.
- iss_tag==0 is illegal. A simulation assertion fires on it.
- Latency: commit value is visible through bypass in the same cycle and from storage the next cycle. Issue rename is visible the next cycle.

Optional Feature:
- Macro: REGFILE_BUSY_VEC_EN.
- Defined: busy_vec[r] = (tag[r]!=0), registered state (no commit bypass). Bit 0 is always 0.
- Undefined: busy_vec tied to 0. No extra logic.

Test Plan:
- Reset mid-operation:
  - Stimulus: load tag[3]=7, val[3]=0x55, then pulse rst asynchronously between edges.
  - Response: rd_val/rd_tag for x3 read 0 immediately, before the next edge.
- Issue then commit:
  - Stimulus: issue x5 tag 4. Next cycle read x5.
  - Response: rd_tag=4.
  - Stimulus: commit port0 x5 tag 4 val 0x1234.
  - Response: same-cycle read gives val 0x1234, tag 0. The following cycle storage holds the same.
- Stale commit:
  - Stimulus: issue x7 tag 2, then issue x7 tag 9, then commit x7 tag 2 val 0xAA.
  - Response: val[7]=0xAA, tag[7] stays 9, reads return tag 9.
- Dual commit, same rd:
  - Stimulus: tag[8]=6. Port0 commits x8 tag 3 val 0x11; port1 commits x8 tag 6 val 0x22.
  - Response: bypass and storage give 0x22, tag[8]=0.
- Issue beats commit clear:
  - Stimulus: tag[4]=1. Same cycle: commit x4 tag 1 val 0x9, issue x4 tag 12.
  - Response: val[4]=0x9, tag[4]=12.
- clr with rdy=0, then clr with rdy=1:
  - Stimulus: tags on x1..x3, clr=1, rdy=0.
  - Response: all tags 0, vals unchanged.
  - Stimulus: clr=1, rdy=1, commit x2 val 0x77.
  - Response: val[2]=0x77, tags 0. busy_vec=0 when REGFILE_BUSY_VEC_EN is defined.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: architectural register file with per-register rename tags.
// NUM_READ combinational read ports with commit bypass, one issue-rename
// port and NUM_COMMIT in-order commit ports (higher port number = younger).
// Optional feature macro: REGFILE_BUSY_VEC_EN (registered busy bitmap;
// when undefined, busy_vec is tied to zero).
module regfile_mp #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_COMMIT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           clr,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_rd,
    input  logic [TAG_W-1:0]               iss_tag,
    input  logic [NUM_COMMIT-1:0]          cm_en,
    input  logic [NUM_COMMIT*ADDR_W-1:0]   cm_rd,
    input  logic [NUM_COMMIT*TAG_W-1:0]    cm_tag,
    input  logic [NUM_COMMIT*DATA_W-1:0]   cm_val,
    input  logic [NUM_READ*ADDR_W-1:0]     rd_addr,
    output logic [NUM_READ*DATA_W-1:0]     rd_val,
    output logic [NUM_READ*TAG_W-1:0]      rd_tag,
    output logic [(2**ADDR_W)-1:0]         busy_vec
);

    localparam int NUM_REGS = 2**ADDR_W;

    // Committed values and youngest-writer tags (tag 0 = no pending writer).
    logic [DATA_W-1:0] r_val [NUM_REGS];
    logic [TAG_W-1:0]  r_tag [NUM_REGS];

    // Unpacked commit ports and their qualification flags.
    logic [ADDR_W-1:0]     w_cm_rd    [NUM_COMMIT];
    logic [TAG_W-1:0]      w_cm_tag   [NUM_COMMIT];
    logic [DATA_W-1:0]     w_cm_val   [NUM_COMMIT];
    logic [NUM_COMMIT-1:0] w_cm_eff;
    logic [NUM_COMMIT-1:0] w_cm_match;

    // Per-read-port working values.
    logic [ADDR_W-1:0]     w_rd_addr  [NUM_READ];
    logic [DATA_W-1:0]     w_rd_val   [NUM_READ];
    logic [TAG_W-1:0]      w_rd_tag   [NUM_READ];

    // Unpack commit ports; a port matches only against the pre-cycle tag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_cm_eff   = '0;
        w_cm_match = '0;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            w_cm_rd[k]    = cm_rd[k*ADDR_W +: ADDR_W];
            w_cm_tag[k]   = cm_tag[k*TAG_W +: TAG_W];
            w_cm_val[k]   = cm_val[k*DATA_W +: DATA_W];
            w_cm_eff[k]   = cm_en[k] && (w_cm_rd[k] != '0);
            w_cm_match[k] = w_cm_eff[k] && (r_tag[w_cm_rd[k]] == w_cm_tag[k]);
        end
    end

    // Read ports: storage, overridden by the youngest matching commit.
    always_comb begin
        rd_val = '0;
        rd_tag = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            w_rd_addr[p] = rd_addr[p*ADDR_W +: ADDR_W];
            w_rd_val[p]  = r_val[w_rd_addr[p]];
            w_rd_tag[p]  = r_tag[w_rd_addr[p]];
            // Ascending scan: a younger matching port overrides an older one.
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (w_cm_match[k] && (w_cm_rd[k] == w_rd_addr[p])) begin
                    w_rd_val[p] = w_cm_val[k];
                    w_rd_tag[p] = '0;
                end
            end
            if (w_rd_addr[p] == '0) begin
                w_rd_val[p] = '0;
                w_rd_tag[p] = '0;
            end
            rd_val[p*DATA_W +: DATA_W] = w_rd_val[p];
            rd_tag[p*TAG_W +: TAG_W]   = w_rd_tag[p];
        end
    end

    // State update: flush, freeze, or commits followed by issue rename.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this storage is a flop array that must read as zero right after reset, so every entry is reset.
            for (int r = 0; r < NUM_REGS; r++) begin
                r_val[r] <= '0;
                r_tag[r] <= '0;
            end
        end else if (clr) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_tag[r] <= '0;
            end
            if (rdy) begin
                for (int k = 0; k < NUM_COMMIT; k++) begin
                    if (w_cm_eff[k]) begin
                        r_val[w_cm_rd[k]] <= w_cm_val[k];
                    end
                end
            end
        end else if (rdy) begin
            // NOTE: with non-blocking assignments the last one executed wins, so port order gives youngest-wins and the issue write below overrides a commit clear.
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (w_cm_eff[k]) begin
                    r_val[w_cm_rd[k]] <= w_cm_val[k];
                end
                if (w_cm_match[k]) begin
                    r_tag[w_cm_rd[k]] <= '0;
                end
            end
            if (iss_en && (iss_rd != '0)) begin
                r_tag[iss_rd] <= iss_tag;
            end
        end
    end

`ifdef REGFILE_BUSY_VEC_EN
    // Busy bitmap from registered tags only; register 0 is never busy.
    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (r_tag[r] != '0);
        end
    end
`else
    assign busy_vec = '0;
`endif

    // Tag 0 is reserved for "no pending writer" and must never be allocated.
    a_iss_tag_nonzero : assert property (@(posedge clk) disable iff (rst)
        iss_en |-> (iss_tag != '0))
        else $error("regfile_mp: issue with reserved tag 0");

endmodule
